// File: rtl/mtip_pkg.sv
// mtip_pkg: shared state encoding and constants for the MTIP PIO arbiter.
package mtip_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'b001,
        ST_ACCESS = 3'b010,
        ST_DONE   = 3'b100
    } state_e;

    localparam int          TMO_CYC_DEF = 1023;
    localparam logic [31:0] TMO_RDATA   = 32'hDEAD_BEEF;

endpackage

// File: rtl/mtip_pio_arb_rr_arb.sv
// rr_arb: round-robin selector; the search starts one past last_owner and wraps.
//   req        : per-requester request levels
//   last_owner : index of the previously served requester
//   gnt        : one-hot grant (all zero when nothing requests)
//   idx        : index of the granted requester
module rr_arb #(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0] req,
    input  logic [2:0]      last_owner,
    output logic [NREQ-1:0] gnt,
    output logic [2:0]      idx
);

    logic found;
    int   t;

    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        t     = 0;
        for (int i = 1; i <= NREQ; i++) begin
            t = int'(last_owner) + i;
            if (t >= NREQ) t = t - NREQ;
            for (int j = 0; j < NREQ; j++) begin
                if (!found && req[j] && j == t) begin
                    gnt[j] = 1'b1;
                    idx    = 3'(j);
                    found  = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/mtip_pio_arb.sv
// mtip_pio_arb: round-robin arbiter sharing one MTIP register port among NREQ requesters.
//   iCLK_100M / iRST_100M         : clock, async active-high reset
//   iREQ / iREQ_WR / iREQ_ADDR / iREQ_WDATA : per-requester access requests
//   oREQ_DONE / oREQ_RDATA / oREQ_TMO       : completion pulse, read data, abort flag
//   oMTIP_REG_*/iMTIP_REG_*       : MTIP register port
//   oGNT_ID                       : current or last owner index
module mtip_pio_arb
    import mtip_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int TMO_CYC = TMO_CYC_DEF
) (
    input  logic               iCLK_100M,
    input  logic               iRST_100M,
    input  logic [NREQ-1:0]    iREQ,
    input  logic [NREQ-1:0]    iREQ_WR,
    input  logic [NREQ*10-1:0] iREQ_ADDR,
    input  logic [NREQ*32-1:0] iREQ_WDATA,
    output logic [NREQ-1:0]    oREQ_DONE,
    output logic [31:0]        oREQ_RDATA,
    output logic               oREQ_TMO,
    output logic [9:0]         oMTIP_REG_ADDR,
    output logic [31:0]        oMTIP_REG_DATA_IN,
    output logic               oMTIP_REG_RD,
    output logic               oMTIP_REG_WR,
    input  logic [31:0]        iMTIP_REG_DATA_OUT,
    input  logic               iMTIP_REG_BUSY,
    output logic [2:0]         oGNT_ID
);

    localparam logic [9:0] TMO_LAST = 10'(TMO_CYC - 1);

    state_e            state_q, state_d;
    logic [9:0]        cnt_q, cnt_d;
    logic [2:0]        last_q, last_d;
    logic [2:0]        owner_q, owner_d;
    logic [NREQ-1:0]   owner_oh_q, owner_oh_d;
    logic              wr_q, wr_d;
    logic [9:0]        addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              tmo_q, tmo_d;
    logic [NREQ-1:0]   gnt;
    logic [2:0]        gnt_idx;

    rr_arb #(.NREQ(NREQ)) u_rr_arb (
        .req        (iREQ),
        .last_owner (last_q),
        .gnt        (gnt),
        .idx        (gnt_idx)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        last_d     = last_q;
        owner_d    = owner_q;
        owner_oh_d = owner_oh_q;
        wr_d       = wr_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        tmo_d      = tmo_q;
        case (state_q)
            ST_IDLE: begin
                if (|iREQ) begin
                    state_d    = ST_ACCESS;
                    cnt_d      = '0;
                    owner_d    = gnt_idx;
                    owner_oh_d = gnt;
                    for (int k = 0; k < NREQ; k++) begin
                        if (gnt[k]) begin
                            wr_d    = iREQ_WR[k];
                            addr_d  = iREQ_ADDR[k*10 +: 10];
                            wdata_d = iREQ_WDATA[k*32 +: 32];
                        end
                    end
                end
            end
            ST_ACCESS: begin
                if (!iMTIP_REG_BUSY) begin
                    state_d = ST_DONE;
                    tmo_d   = 1'b0;
                    // A write leaves the last read data in place.
                    rdata_d = wr_q ? rdata_q : iMTIP_REG_DATA_OUT;
                end else if (cnt_q == TMO_LAST) begin
                    state_d = ST_DONE;
                    tmo_d   = 1'b1;
                    rdata_d = TMO_RDATA;
                end else begin
                    cnt_d = cnt_q + 10'd1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                last_d  = owner_q;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge iCLK_100M or posedge iRST_100M) begin
        if (iRST_100M) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            last_q     <= 3'(NREQ - 1);
            owner_q    <= '0;
            owner_oh_q <= '0;
            wr_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            tmo_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            last_q     <= last_d;
            owner_q    <= owner_d;
            owner_oh_q <= owner_oh_d;
            wr_q       <= wr_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
            tmo_q      <= tmo_d;
        end
    end

    // Strobes decode straight from the state flops so an async reset drops them at once.
    assign oMTIP_REG_RD      = (state_q == ST_ACCESS) && !wr_q;
    assign oMTIP_REG_WR      = (state_q == ST_ACCESS) && wr_q;
    assign oREQ_DONE         = (state_q == ST_DONE) ? owner_oh_q : '0;
    assign oREQ_RDATA        = rdata_q;
    assign oREQ_TMO          = tmo_q;
    assign oMTIP_REG_ADDR    = addr_q;
    assign oMTIP_REG_DATA_IN = wdata_q;
    assign oGNT_ID           = owner_q;

endmodule

// File: tb/tb_mtip_pio_arb.sv
// tb_mtip_pio_arb: directed self-checking bench for mtip_pio_arb (NREQ=4, TMO_CYC=8).
module tb_mtip_pio_arb;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  req = '0;
    logic [3:0]  req_wr = '0;
    logic [39:0] req_addr = '0;
    logic [127:0] req_wdata = '0;
    logic [3:0]  done;
    logic [31:0] rdata;
    logic        tmo;
    logic [9:0]  m_addr;
    logic [31:0] m_din;
    logic        m_rd, m_wr;
    logic [31:0] m_dout = '0;
    logic        m_busy = 1'b0;
    logic [2:0]  gnt_id;
    int          checks = 0;
    int          errors = 0;

    mtip_pio_arb #(.NREQ(4), .TMO_CYC(8)) dut (
        .iCLK_100M          (clk),
        .iRST_100M          (rst),
        .iREQ               (req),
        .iREQ_WR            (req_wr),
        .iREQ_ADDR          (req_addr),
        .iREQ_WDATA         (req_wdata),
        .oREQ_DONE          (done),
        .oREQ_RDATA         (rdata),
        .oREQ_TMO           (tmo),
        .oMTIP_REG_ADDR     (m_addr),
        .oMTIP_REG_DATA_IN  (m_din),
        .oMTIP_REG_RD       (m_rd),
        .oMTIP_REG_WR       (m_wr),
        .iMTIP_REG_DATA_OUT (m_dout),
        .iMTIP_REG_BUSY     (m_busy),
        .oGNT_ID            (gnt_id)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        tick;
        tick;
        chk("rst_rd", 32'(m_rd), 32'd0);
        chk("rst_wr", 32'(m_wr), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_tmo", 32'(tmo), 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_addr", 32'(m_addr), 32'd0);
        chk("rst_din", m_din, 32'd0);
        chk("rst_gnt", 32'(gnt_id), 32'd0);
        rst = 1'b0;
        tick;

        // All four request at once: served 0,1,2,3 with done pulses 3 cycles apart.
        for (int k = 0; k < 4; k++) begin
            req_addr[k*10 +: 10]  = 10'(12'h100 + k);
            req_wdata[k*32 +: 32] = 32'hA000_0000 + 32'(k);
        end
        req_wr = 4'hF;
        req    = 4'hF;
        for (int k = 0; k < 4; k++) begin
            tick;
            chk("all_gnt", 32'(gnt_id), 32'(k));
            chk("all_wr", 32'(m_wr), 32'd1);
            chk("all_addr", 32'(m_addr), 32'h100 + 32'(k));
            chk("all_din", m_din, 32'hA000_0000 + 32'(k));
            tick;
            chk("all_done", 32'(done), 32'(1 << k));
            req[k] = 1'b0;
            tick;
            chk("all_done_lo", 32'(done), 32'd0);
        end

        // Single read from requester 2, busy for 3 access cycles.
        req_wr = '0;
        req_addr[20 +: 10] = 10'h020;
        m_busy = 1'b1;
        req[2] = 1'b1;
        tick;
        chk("rd_gnt", 32'(gnt_id), 32'd2);
        chk("rd_addr", 32'(m_addr), 32'h020);
        chk("rd_c1", 32'(m_rd), 32'd1);
        tick;
        chk("rd_c2", 32'(m_rd), 32'd1);
        tick;
        chk("rd_c3", 32'(m_rd), 32'd1);
        tick;
        chk("rd_c4", 32'(m_rd), 32'd1);
        chk("rd_wr_lo", 32'(m_wr), 32'd0);
        m_busy = 1'b0;
        m_dout = 32'h1234_5678;
        tick;
        chk("rd_strobe_off", 32'(m_rd), 32'd0);
        chk("rd_done", 32'(done), 32'b0100);
        chk("rd_data", rdata, 32'h1234_5678);
        chk("rd_tmo", 32'(tmo), 32'd0);
        req[2] = 1'b0;
        m_dout = 32'h0;
        tick;
        chk("rd_done_lo", 32'(done), 32'd0);
        chk("rd_hold", rdata, 32'h1234_5678);

        // Requester 1 stays up while requester 3 joins: 1,3,1.
        req[1] = 1'b1;
        tick;
        chk("alt_g1", 32'(gnt_id), 32'd1);
        req[3] = 1'b1;
        tick;
        chk("alt_d1", 32'(done), 32'b0010);
        tick;
        tick;
        chk("alt_g3", 32'(gnt_id), 32'd3);
        tick;
        chk("alt_d3", 32'(done), 32'b1000);
        req[3] = 1'b0;
        tick;
        tick;
        chk("alt_g1b", 32'(gnt_id), 32'd1);
        tick;
        chk("alt_d1b", 32'(done), 32'b0010);
        req[1] = 1'b0;
        tick;

        // Write from requester 0 with busy stuck: aborts after 8 strobe cycles.
        req_wr[0] = 1'b1;
        m_busy = 1'b1;
        req[0] = 1'b1;
        tick;
        chk("tmo_gnt", 32'(gnt_id), 32'd0);
        for (int i = 0; i < 8; i++) begin
            chk("tmo_wr_hi", 32'(m_wr), 32'd1);
            tick;
        end
        chk("tmo_wr_off", 32'(m_wr), 32'd0);
        chk("tmo_done", 32'(done), 32'b0001);
        chk("tmo_flag", 32'(tmo), 32'd1);
        chk("tmo_rdata", rdata, 32'hDEAD_BEEF);
        req[0] = 1'b0;
        m_busy = 1'b0;
        tick;
        chk("tmo_hold", 32'(tmo), 32'd1);
        chk("tmo_rdata_hold", rdata, 32'hDEAD_BEEF);

        // Reset pulse during a write access from requester 2.
        req_wr[2] = 1'b1;
        m_busy = 1'b1;
        req[2] = 1'b1;
        tick;
        chk("rst_mid_gnt", 32'(gnt_id), 32'd2);
        chk("rst_mid_wr", 32'(m_wr), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("rst_mid_wr_off", 32'(m_wr), 32'd0);
        chk("rst_mid_done", 32'(done), 32'd0);
        chk("rst_mid_tmo", 32'(tmo), 32'd0);
        m_busy = 1'b0;
        req_wr[0] = 1'b0;
        req[0] = 1'b1;
        tick;
        rst = 1'b0;
        chk("rel_done", 32'(done), 32'd0);
        tick;
        chk("rel_gnt0", 32'(gnt_id), 32'd0);
        chk("rel_no_done", 32'(done), 32'd0);
        tick;
        chk("rel_done0", 32'(done), 32'b0001);
        req[0] = 1'b0;
        tick;
        tick;
        chk("rel_gnt2", 32'(gnt_id), 32'd2);
        tick;
        chk("rel_done2", 32'(done), 32'b0100);
        // Requester 0 rises during DONE so it is high in the next IDLE cycle.
        req[2] = 1'b0;
        req[0] = 1'b1;
        tick;
        chk("drop_idle", 32'(done), 32'd0);
        req[0] = 1'b0;
        req[1] = 1'b1;
        req_wr[1] = 1'b0;
        tick;
        chk("drop_gnt1", 32'(gnt_id), 32'd1);
        tick;
        chk("drop_done1", 32'(done), 32'b0010);
        req[1] = 1'b0;
        tick;
        tick;
        chk("drop_no_rd", 32'(m_rd), 32'd0);
        chk("drop_no_wr", 32'(m_wr), 32'd0);
        chk("drop_gnt_keep", 32'(gnt_id), 32'd1);
        tick;
        chk("drop_no_done", 32'(done), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mtip_pio_arb.md
MTIP_PIO_ARB -- requirements
Module: mtip_pio_arb

Interface
REQ-001 SHALL have parameter NREQ, default 4, meaning number of requesters (2..8).
REQ-002 SHALL have parameter TMO_CYC, default 1023, meaning maximum busy cycles per access before abort (10-bit).
REQ-003 SHALL have port iCLK_100M  input  1  the single clock for all logic.
REQ-004 SHALL have port iRST_100M  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port iREQ  input  NREQ  per-requester access request, level, held until done.
REQ-006 SHALL have port iREQ_WR  input  NREQ  1 = write, 0 = read, valid while iREQ is high.
REQ-007 SHALL have port iREQ_ADDR  input  NREQ*10  per-requester byte address, requester k in bits [10k+9:10k].
REQ-008 SHALL have port iREQ_WDATA  input  NREQ*32  per-requester write data, requester k in bits [32k+31:32k].
REQ-009 SHALL have port oREQ_DONE  output  NREQ  one-cycle completion pulse to the owning requester.
REQ-010 SHALL have port oREQ_RDATA  output  32  read data, valid with oREQ_DONE of a read.
REQ-011 SHALL have port oREQ_TMO  output  1  with oREQ_DONE, marks an aborted access.
REQ-012 SHALL have port oMTIP_REG_ADDR  output  10  MTIP register address.
REQ-013 SHALL have port oMTIP_REG_DATA_IN  output  32  MTIP write data.
REQ-014 SHALL have port oMTIP_REG_RD / oMTIP_REG_WR  output  1 each  MTIP strobes.
REQ-015 SHALL have port iMTIP_REG_DATA_OUT  input  32  MTIP read data.
REQ-016 SHALL have port iMTIP_REG_BUSY  input  1  MTIP busy, access completes in the first strobe cycle where it is low.
REQ-017 SHALL have port oGNT_ID  output  3  index of the current or last owner, for debug.

Function
REQ-018 SHALL use one-hot states IDLE, ACCESS, DONE.
REQ-019 In IDLE with any iREQ high, SHALL grant round-robin, starting the search at index last_owner+1 modulo NREQ, and SHALL register address, data and direction from the winner, then go to ACCESS.
REQ-020 In ACCESS, SHALL assert exactly one of oMTIP_REG_RD/oMTIP_REG_WR and SHALL hold address and data stable.
REQ-021 In ACCESS with iMTIP_REG_BUSY low, SHALL go to DONE and capture iMTIP_REG_DATA_OUT on a read; minimum latency is 3 cycles from iREQ to oREQ_DONE.
REQ-022 In ACCESS, SHALL count busy cycles; when the count reaches TMO_CYC with busy still high, SHALL deassert the strobe, go to DONE, set oREQ_TMO, and drive oREQ_RDATA = 32'hDEAD_BEEF.
REQ-023 In DONE, SHALL pulse oREQ_DONE[owner] for one cycle, update last_owner, and return to IDLE; the new arbitration occurs in the following cycle.
REQ-024 SHALL ignore a request that drops in IDLE before grant; a request dropped after grant SHALL still complete, and its done pulse SHALL be ignored.
REQ-025 With simultaneous requests, each SHALL be served exactly once per rotation; no requester SHALL wait more than NREQ accesses.
REQ-026 oREQ_RDATA and oREQ_TMO SHALL hold their values until the next DONE.
REQ-027 An illegal state SHALL recover to IDLE in one cycle.

Reset
REQ-028 On iRST_100M, SHALL enter IDLE, set last_owner = NREQ-1 so that index 0 wins first, and clear the timeout counter.
REQ-029 On iRST_100M, SHALL drive all outputs to 0, including RD/WR, DONE, TMO, RDATA, ADDR, DATA_IN and oGNT_ID.
REQ-030 Reset asserted mid-access SHALL drop the strobe immediately; no oREQ_DONE pulse SHALL follow reset release.

Structure
REQ-031 The state encoding, TMO_CYC default and DEAD_BEEF constant SHALL live in shared package mtip_pkg.
REQ-032 The round-robin selector SHALL be a sub-module rr_arb (inputs req and last_owner; outputs a one-hot grant and an index).

Verification
REQ-033 The bench SHALL cover: single read from requester 2, addr 10'h020, busy 3 cycles, data 32'h1234_5678 -> RD high 4 cycles, oREQ_DONE[2] with RDATA 32'h1234_5678, TMO 0.
REQ-034 The bench SHALL cover: all 4 requesters requesting at once, busy 0 -> grants in order 0,1,2,3, each oREQ_DONE 3 cycles apart.
REQ-035 The bench SHALL cover: requester 1 requesting continuously while requester 3 requests -> grants alternate 1,3,1.
REQ-036 The bench SHALL cover: write with busy stuck high, TMO_CYC=8 -> WR high 8 cycles, then DONE with TMO 1 and RDATA 32'hDEAD_BEEF.
REQ-037 The bench SHALL cover: reset pulse during ACCESS -> WR low in the same cycle, no DONE after release, next grant goes to 0.
REQ-038 The bench SHALL cover: requester 0 dropping iREQ in IDLE the same cycle another requester rises -> only the other requester is served.
